sdram_arbiter: RTL

- Shares the single SDRAM controller port between the playback requester (read-only) and the recording requester (read/write).
- Each requester holds read/write high with a stable address (and write data) until it sees a one-cycle finished pulse.
- The arbiter grants one requester at a time using round-robin, latches the command, and drives the SDRAM port until the SDRAM reports finished.
- It then routes the finished pulse back to the granted requester. A watchdog releases a hung access.

---
 rtl/sdram_arbiter_if.sv | 48 ++++
 rtl/sdram_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_if.sv
// Bundle of the requester and SDRAM-controller signals around the arbiter.
// The master side drives requests and SDRAM responses; the arbiter takes the slave side.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    logic              play_read;
    logic [ADDR_W-1:0] play_addr;
    logic [DATA_W-1:0] play_readdata;
    logic              play_finished;

    logic              rec_read;
    logic              rec_write;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_writedata;
    logic [DATA_W-1:0] rec_readdata;
    logic              rec_finished;

    logic              sdram_read;
    logic              sdram_write;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_writedata;
    logic [DATA_W-1:0] sdram_readdata;
    logic              sdram_finished;

    logic [1:0]        arb_grant;
    logic              arb_timeout;

    modport master (
        output play_read, play_addr,
        output rec_read, rec_write, rec_addr, rec_writedata,
        output sdram_readdata, sdram_finished,
        input  play_readdata, play_finished,
        input  rec_readdata, rec_finished,
        input  sdram_read, sdram_write, sdram_addr, sdram_writedata,
        input  arb_grant, arb_timeout
    );

    modport slave (
        input  play_read, play_addr,
        input  rec_read, rec_write, rec_addr, rec_writedata,
        input  sdram_readdata, sdram_finished,
        output play_readdata, play_finished,
        output rec_readdata, rec_finished,
        output sdram_read, sdram_write, sdram_addr, sdram_writedata,
        output arb_grant, arb_timeout
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between playback (read-only)
// and recording (read/write), with a watchdog that releases a hung access.
module sdram_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sdram_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    localparam logic [1:0] GRANT_PLAY = 2'b01;
    localparam logic [1:0] GRANT_REC  = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e            state_q,   state_d;
    logic [1:0]        grant_q,   grant_d;
    logic              last_rec_q, last_rec_d;
    logic              cmd_rd_q,  cmd_rd_d;
    logic              cmd_wr_q,  cmd_wr_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              timeout_q, timeout_d;

    logic              req_p;
    logic              req_r;
    logic [CNT_W-1:0]  cnt_inc;

    assign req_p   = bus.play_read;
    assign req_r   = bus.rec_read | bus.rec_write;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        // NOTE: every next-state value defaults to its current value first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        grant_d    = grant_q;
        last_rec_d = last_rec_q;
        cmd_rd_d   = cmd_rd_q;
        cmd_wr_d   = cmd_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // On a tie, the requester that was not served last wins.
                if (req_p && (!req_r || last_rec_q)) begin
                    state_d  = S_BUSY;
                    grant_d  = GRANT_PLAY;
                    cmd_rd_d = 1'b1;
                    cmd_wr_d = 1'b0;
                    addr_d   = bus.play_addr;
                    wdata_d  = '0;
                end else if (req_r) begin
                    state_d  = S_BUSY;
                    grant_d  = GRANT_REC;
                    cmd_rd_d = bus.rec_read;
                    cmd_wr_d = bus.rec_write;
                    addr_d   = bus.rec_addr;
                    wdata_d  = bus.rec_writedata;
                end
            end

            S_BUSY: begin
                if (bus.sdram_finished || cnt_inc == TIMEOUT_C) begin
                    state_d    = S_IDLE;
                    last_rec_d = grant_q[1];
                    grant_d    = '0;
                    cmd_rd_d   = 1'b0;
                    cmd_wr_d   = 1'b0;
                    cnt_d      = '0;
                    timeout_d  = !bus.sdram_finished;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            last_rec_q <= 1'b1;
            cmd_rd_q   <= 1'b0;
            cmd_wr_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_rec_q <= last_rec_d;
            cmd_rd_q   <= cmd_rd_d;
            cmd_wr_q   <= cmd_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.sdram_read      = cmd_rd_q;
    assign bus.sdram_write     = cmd_wr_q;
    assign bus.sdram_addr      = addr_q;
    assign bus.sdram_writedata = wdata_q;
    assign bus.arb_grant       = grant_q;
    assign bus.arb_timeout     = timeout_q;

    // Completion is routed straight through so the requester sees it in the SDRAM's own cycle.
    assign bus.play_finished = bus.sdram_finished & grant_q[0] & (state_q == S_BUSY);
    assign bus.rec_finished  = bus.sdram_finished & grant_q[1] & (state_q == S_BUSY);
    assign bus.play_readdata = bus.sdram_readdata;
    assign bus.rec_readdata  = bus.sdram_readdata;
endmodule
